bsg_nonsynth_axi_burst_mem: RTL and testbench
=============================================

Name: bsg_nonsynth_axi_burst_mem

Overview:
Simulation-only AXI4 slave memory model that succeeds the plain AXI memory used on the BP memory port in the FPGA host test harness. It adds the FIXED, INCR and WRAP burst types, narrow transfers through awsize/arsize, and byte-strobe writes. It also adds configurable write-response and read-data latency, plus SLVERR on out-of-range or malformed bursts. Read and write channels run independently, with one outstanding transaction per direction.

Parameters:
axi_id_width_p, 4, width of the AW/AR/B/R ID fields
axi_addr_width_p, 32, address width
axi_data_width_p, 64, data width; must be a power of two and at least 8
axi_len_width_p, 8, width of awlen/arlen
mem_els_p, 1024, number of data-width words in the memory
base_addr_p, 0, byte address that maps to word 0
write_latency_p, 0, extra cycles from the last W handshake to bvalid
read_latency_p, 0, extra cycles from the AR handshake to the first rvalid

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, synchronous, active-high
axi_awid_i  in  axi_id_width_p  write ID
axi_awaddr_i  in  axi_addr_width_p  write start byte address
axi_awlen_i  in  axi_len_width_p  write beats minus 1
axi_awsize_i  in  3  log2 of bytes per write beat
axi_awburst_i  in  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP
axi_awvalid_i / axi_awready_o  in/out  1  AW handshake
axi_wdata_i  in  axi_data_width_p  write data
axi_wstrb_i  in  axi_data_width_p/8  byte enables
axi_wlast_i  in  1  last write beat
axi_wvalid_i / axi_wready_o  in/out  1  W handshake
axi_bid_o  out  axi_id_width_p  response ID
axi_bresp_o  out  2  write response: 0 OKAY, 2 SLVERR
axi_bvalid_o / axi_bready_i  out/in  1  B handshake
axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i  in  as the AW fields  read command
axi_arvalid_i / axi_arready_o  in/out  1  AR handshake
axi_rid_o  out  axi_id_width_p  read ID
axi_rdata_o  out  axi_data_width_p  read data
axi_rresp_o  out  2  read response
axi_rlast_o  out  1  last read beat
axi_rvalid_o / axi_rready_i  out/in  1  R handshake

Behaviour:
- Reset applies on the first clock edge with reset_i high.
  - All valid and ready outputs go to 0; id, resp, data and last outputs go to 0.
  - Both FSMs go to IDLE.
  - Memory contents are kept, not cleared.
  - Reset in the middle of a burst abandons it; no B or R is produced for the abandoned transaction.
- Write FSM states: W_IDLE, W_DATA, W_WAIT, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, clear the error flag, set beat count to 0, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes with wstrb set to word (beat_addr-base_addr_p)>>log2(data bytes), then advances beat_addr.
  - Set the error flag when wlast does not equal (beat==len).
  - Leave W_DATA after beat len; wlast is not used to end the burst.
  - Go to W_WAIT when write_latency_p>0, otherwise go directly to W_RESP.
  - W_WAIT: count write_latency_p cycles, then go to W_RESP.
  - W_RESP: bvalid=1 with bid set to the latched id and bresp=2 if the error flag is set, else 0. Hold until bready, then go to W_IDLE.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch the command and go to R_WAIT, or to R_DATA if read_latency_p is 0.
  - R_DATA: rvalid=1 and rdata is the memory word at beat_addr. rlast=(beat==len).
  - While rvalid is high and rready is low, rdata, rresp and rlast stay stable.
  - Beats are issued back-to-back while rready is held high. After the rlast handshake, go to R_IDLE.
  - First rvalid occurs 1+read_latency_p cycles after the AR handshake. bvalid occurs 1+write_latency_p cycles after the last W handshake.
- Address generation per beat, with B = 1<<size:
  - FIXED: address is unchanged.
  - INCR: next = (addr & ~(B-1)) + B.
  - WRAP: wrap boundary is (len+1)*B. Upper address bits stay fixed; the low bits increment modulo the boundary.
- Error conditions; every beat of an errored transaction returns SLVERR:
  - Any beat address outside [base_addr_p, base_addr_p + mem_els_p*data_bytes).
  - size greater than log2(data bytes).
  - WRAP with len not in {1,3,7,15}.
  - burst type 3.
- In an errored transaction, writes are dropped and reads return rdata=0.
- A read beat and a write beat to the same word in the same cycle: the read returns the old data. Writes are visible from the next cycle onward.
- The read and write FSMs are fully independent; there is no ordering between them.

Decomposition:
- Shared package bsg_axi_pkg holds:
  - the burst enum: FIXED, INCR, WRAP;
  - the resp constants: OKAY, EXOKAY, SLVERR, DECERR;
  - a size-to-bytes function.
- Sub-module bsg_axi_burst_addr_gen is instantiated once per direction.
  - Inputs: start addr, len, size, burst, load, advance.
  - Outputs: current addr, beat count, last, illegal.
  - Illegal covers bad size, bad WRAP len and burst type 3.

Test Plan:
- INCR write at 0x100, len 3, size 3, data 0x11,0x22,0x33,0x44, awid 5 -> bresp 0, bid 5; INCR read of the same range with arid 9 -> four beats 0x11..0x44, rlast only on beat 4, rid 9.
- WRAP read, addr 0x118, len 3, size 3 -> beats read from 0x118, 0x100, 0x108, 0x110.
- Write 0xFFFFFFFF_FFFFFFFF to 0x200, then write 0x0_12345678 with wstrb 0x0F -> readback is 0xFFFFFFFF_12345678.
- Write to 0x2000 (out of range with the default parameters) -> bresp 2 and memory unchanged; read of 0x2000 -> rresp 2, rdata 0.
- read_latency_p=5, AR handshake at cycle N -> first rvalid at N+6. Drop rready for 3 cycles mid-burst -> rdata and rlast stable throughout; wlast asserted early on a len-3 write -> bresp 2.
- Assert reset_i during beat 2 of a len-7 read -> rvalid low the next cycle and arready high afterwards; a following INCR write/read pair completes with OKAY.

Source files
------------

// File: rtl/bsg_axi_pkg.sv
// Shared AXI definitions for the burst memory model: burst and response encodings,
// FSM state types and a size-to-bytes helper.
package bsg_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/bsg_axi_burst_addr_gen.sv
// Per-direction AXI burst address generator: latches a command, steps the beat
// address, and flags malformed or out-of-range bursts for the whole transaction.
module bsg_axi_burst_addr_gen
    import bsg_axi_pkg::*;
#(
    parameter int              addr_width_p = 32,
    parameter int              len_width_p  = 8,
    parameter int              data_bytes_p = 8,
    parameter longint unsigned base_addr_p  = 0,
    parameter longint unsigned mem_bytes_p  = 8192
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic                    advance_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [len_width_p-1:0]  len_i,
    input  logic [2:0]              size_i,
    input  logic [1:0]              burst_i,
    output logic [addr_width_p-1:0] addr_o,
    output logic [len_width_p-1:0]  beat_o,
    output logic                    last_o,
    output logic                    illegal_o,
    output logic                    oor_o
);

    localparam int lg_db_lp = $clog2(data_bytes_p);
    localparam int wide_lp  = addr_width_p + len_width_p + 9;
    typedef logic [wide_lp-1:0] wide_t;

    logic [addr_width_p-1:0] start_r, addr_r;
    logic [len_width_p-1:0]  len_r, beat_r;
    logic [2:0]              size_r;
    logic [1:0]              burst_r;

    wide_t bytes_w, bound_w, cur_w, start_w, step_w, next_w, lo_w, hi_w;

    // Range is judged over the whole burst up front so every beat reports the same resp.
    always_comb begin
        bytes_w = wide_t'(size_to_bytes(size_r));
        bound_w = (wide_t'(len_r) + wide_t'(1)) * bytes_w;
        cur_w   = wide_t'(addr_r);
        start_w = wide_t'(start_r);
        step_w  = (cur_w & ~(bytes_w - wide_t'(1))) + bytes_w;
        next_w  = cur_w;
        lo_w    = start_w;
        hi_w    = start_w;
        case (burst_r)
            2'(INCR): begin
                next_w = step_w;
                hi_w   = (start_w & ~(bytes_w - wide_t'(1))) + wide_t'(len_r) * bytes_w;
            end
            2'(WRAP): begin
                next_w = (cur_w & ~(bound_w - wide_t'(1))) | (step_w & (bound_w - wide_t'(1)));
                lo_w   = start_w & ~(bound_w - wide_t'(1));
                hi_w   = lo_w + bound_w - bytes_w;
            end
            default: ;
        endcase
    end

    assign illegal_o = (size_r > 3'(lg_db_lp)) || (burst_r == 2'd3) ||
                       ((burst_r == 2'(WRAP)) &&
                        !((len_r == len_width_p'(1)) || (len_r == len_width_p'(3)) ||
                          (len_r == len_width_p'(7)) || (len_r == len_width_p'(15))));
    assign oor_o     = (lo_w < wide_t'(base_addr_p)) ||
                       (hi_w >= wide_t'(base_addr_p) + wide_t'(mem_bytes_p));
    assign addr_o    = addr_r;
    assign beat_o    = beat_r;
    assign last_o    = (beat_r == len_r);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            start_r <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            beat_r  <= '0;
            size_r  <= '0;
            burst_r <= '0;
        end else if (load_i) begin
            start_r <= addr_i;
            addr_r  <= addr_i;
            len_r   <= len_i;
            beat_r  <= '0;
            size_r  <= size_i;
            burst_r <= burst_i;
        end else if (advance_i) begin
            addr_r <= next_w[addr_width_p-1:0];
            beat_r <= beat_r + len_width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_nonsynth_axi_burst_mem.sv
// Simulation AXI4 slave memory with FIXED/INCR/WRAP bursts, narrow sizes, byte strobes,
// configurable B/R latency and SLVERR on bad bursts; one transaction per direction.
module bsg_nonsynth_axi_burst_mem
    import bsg_axi_pkg::*;
#(
    parameter int              axi_id_width_p   = 4,
    parameter int              axi_addr_width_p = 32,
    parameter int              axi_data_width_p = 64,
    parameter int              axi_len_width_p  = 8,
    parameter int              mem_els_p        = 1024,
    parameter longint unsigned base_addr_p      = 0,
    parameter int              write_latency_p  = 0,
    parameter int              read_latency_p   = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [axi_len_width_p-1:0]    axi_awlen_i,
    input  logic [2:0]                    axi_awsize_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,
    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,
    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,
    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [axi_len_width_p-1:0]    axi_arlen_i,
    input  logic [2:0]                    axi_arsize_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,
    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i
);

    localparam int              data_bytes_lp = axi_data_width_p / 8;
    localparam int              lg_db_lp      = $clog2(data_bytes_lp);
    localparam int              lg_els_lp     = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam longint unsigned mem_bytes_lp  = longint'(mem_els_p) * longint'(data_bytes_lp);

    logic [axi_data_width_p-1:0] mem [mem_els_p];

    w_state_e w_state_r;
    r_state_e r_state_r;

    logic aw_ready_r, w_ready_r, b_valid_r, ar_ready_r, r_valid_r;
    logic [axi_id_width_p-1:0] w_id_r, b_id_r, r_id_r;
    logic [1:0]  b_resp_r, w_resp_r, w_resp_n;
    logic        w_wlast_err_r;
    logic [31:0] w_cnt_r, r_cnt_r;

    logic [axi_addr_width_p-1:0] w_addr, r_addr;
    logic [axi_len_width_p-1:0]  w_beat_unused, r_beat_unused;
    logic w_last, w_illegal, w_oor, w_err, r_last, r_illegal, r_oor, r_err;
    logic aw_hs, w_hs, ar_hs, r_hs, mem_we;
    logic [lg_els_lp-1:0] w_idx, r_idx;
    logic [axi_data_width_p-1:0] r_live, r_hold_r;
    logic r_stall_r;

    assign aw_hs = (w_state_r == W_IDLE) && axi_awvalid_i && aw_ready_r;
    assign w_hs  = (w_state_r == W_DATA) && axi_wvalid_i && w_ready_r;
    assign ar_hs = (r_state_r == R_IDLE) && axi_arvalid_i && ar_ready_r;
    assign r_hs  = (r_state_r == R_DATA) && r_valid_r && axi_rready_i;

    bsg_axi_burst_addr_gen #(
        .addr_width_p(axi_addr_width_p), .len_width_p(axi_len_width_p),
        .data_bytes_p(data_bytes_lp), .base_addr_p(base_addr_p), .mem_bytes_p(mem_bytes_lp)
    ) w_gen (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(aw_hs), .advance_i(w_hs),
        .addr_i(axi_awaddr_i), .len_i(axi_awlen_i), .size_i(axi_awsize_i), .burst_i(axi_awburst_i),
        .addr_o(w_addr), .beat_o(w_beat_unused), .last_o(w_last), .illegal_o(w_illegal), .oor_o(w_oor)
    );

    bsg_axi_burst_addr_gen #(
        .addr_width_p(axi_addr_width_p), .len_width_p(axi_len_width_p),
        .data_bytes_p(data_bytes_lp), .base_addr_p(base_addr_p), .mem_bytes_p(mem_bytes_lp)
    ) r_gen (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(ar_hs), .advance_i(r_hs),
        .addr_i(axi_araddr_i), .len_i(axi_arlen_i), .size_i(axi_arsize_i), .burst_i(axi_arburst_i),
        .addr_o(r_addr), .beat_o(r_beat_unused), .last_o(r_last), .illegal_o(r_illegal), .oor_o(r_oor)
    );

    assign w_err    = w_illegal || w_oor;
    assign r_err    = r_illegal || r_oor;
    assign w_idx    = lg_els_lp'((w_addr - axi_addr_width_p'(base_addr_p)) >> lg_db_lp);
    assign r_idx    = lg_els_lp'((r_addr - axi_addr_width_p'(base_addr_p)) >> lg_db_lp);
    assign w_resp_n = (w_err || w_wlast_err_r || (axi_wlast_i != w_last)) ? SLVERR : OKAY;
    assign mem_we   = w_hs && !w_err && !reset_i;
    assign r_live   = r_err ? '0 : mem[r_idx];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < data_bytes_lp; b++) begin
                if (axi_wstrb_i[b]) mem[w_idx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_state_r     <= W_IDLE;
            aw_ready_r    <= 1'b0;
            w_ready_r     <= 1'b0;
            b_valid_r     <= 1'b0;
            b_id_r        <= '0;
            b_resp_r      <= OKAY;
            w_resp_r      <= OKAY;
            w_id_r        <= '0;
            w_wlast_err_r <= 1'b0;
            w_cnt_r       <= '0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_ready_r    <= 1'b0;
                        w_ready_r     <= 1'b1;
                        w_id_r        <= axi_awid_i;
                        w_wlast_err_r <= 1'b0;
                        w_state_r     <= W_DATA;
                    end else begin
                        aw_ready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (axi_wlast_i != w_last) w_wlast_err_r <= 1'b1;
                        // The beat count, not wlast, closes the burst.
                        if (w_last) begin
                            w_ready_r <= 1'b0;
                            w_resp_r  <= w_resp_n;
                            w_cnt_r   <= '0;
                            if (write_latency_p > 0) begin
                                w_state_r <= W_WAIT;
                            end else begin
                                b_valid_r <= 1'b1;
                                b_id_r    <= w_id_r;
                                b_resp_r  <= w_resp_n;
                                w_state_r <= W_RESP;
                            end
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt_r == 32'(write_latency_p - 1)) begin
                        b_valid_r <= 1'b1;
                        b_id_r    <= w_id_r;
                        b_resp_r  <= w_resp_r;
                        w_state_r <= W_RESP;
                    end else begin
                        w_cnt_r <= w_cnt_r + 32'd1;
                    end
                end
                W_RESP: begin
                    if (axi_bready_i) begin
                        b_valid_r  <= 1'b0;
                        b_id_r     <= '0;
                        b_resp_r   <= OKAY;
                        aw_ready_r <= 1'b1;
                        w_state_r  <= W_IDLE;
                    end
                end
                default: w_state_r <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_id_r     <= '0;
            r_cnt_r    <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_ready_r <= 1'b0;
                        r_id_r     <= axi_arid_i;
                        r_cnt_r    <= '0;
                        if (read_latency_p == 0) begin
                            r_valid_r <= 1'b1;
                            r_state_r <= R_DATA;
                        end else begin
                            r_state_r <= R_WAIT;
                        end
                    end else begin
                        ar_ready_r <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_r == 32'(read_latency_p - 1)) begin
                        r_valid_r <= 1'b1;
                        r_state_r <= R_DATA;
                    end else begin
                        r_cnt_r <= r_cnt_r + 32'd1;
                    end
                end
                R_DATA: begin
                    if (r_hs && r_last) begin
                        r_valid_r  <= 1'b0;
                        r_id_r     <= '0;
                        ar_ready_r <= 1'b1;
                        r_state_r  <= R_IDLE;
                    end
                end
                default: r_state_r <= R_IDLE;
            endcase
        end
    end

    // A stalled beat is frozen so a concurrent write to that word cannot disturb rdata.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall_r <= 1'b0;
            r_hold_r  <= '0;
        end else if (r_valid_r && !axi_rready_i) begin
            r_stall_r <= 1'b1;
            if (!r_stall_r) r_hold_r <= r_live;
        end else begin
            r_stall_r <= 1'b0;
        end
    end

    assign axi_awready_o = aw_ready_r;
    assign axi_wready_o  = w_ready_r;
    assign axi_bvalid_o  = b_valid_r;
    assign axi_bid_o     = b_id_r;
    assign axi_bresp_o   = b_resp_r;
    assign axi_arready_o = ar_ready_r;
    assign axi_rvalid_o  = r_valid_r;
    assign axi_rid_o     = r_id_r;
    assign axi_rdata_o   = !r_valid_r ? '0 : (r_stall_r ? r_hold_r : r_live);
    assign axi_rresp_o   = (r_valid_r && r_err) ? SLVERR : OKAY;
    assign axi_rlast_o   = r_valid_r && r_last;

endmodule

// File: tb/tb_bsg_nonsynth_axi_burst_mem.sv
// Directed bench for the AXI burst memory: INCR/WRAP/FIXED bursts, strobes, SLVERR cases,
// B/R latency, R-channel stalls and reset in the middle of a read burst.
module tb_bsg_nonsynth_axi_burst_mem;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    int tests  = 0;
    int failed = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    bsg_nonsynth_axi_burst_mem #(
        .axi_id_width_p(4), .axi_addr_width_p(32), .axi_data_width_p(64), .axi_len_width_p(8),
        .mem_els_p(1024), .base_addr_p(0), .write_latency_p(2), .read_latency_p(5)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        failed++;
        $error("FAIL timeout_%s: handshake never completed", tag);
    endtask

    // All channel tasks are entered and left on a falling edge.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("aw");
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("w");
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(output logic [3:0] id, output logic [1:0] resp, output int lat);
        lat = 0;
        bready = 1'b1;
        while (!bvalid && lat < 100) begin @(negedge clk); lat++; end
        if (lat >= 100) timeout("b");
        id = bid; resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("ar");
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic r_recv(output logic [63:0] data, output logic [1:0] resp, output logic last,
                          output logic [3:0] id, output int lat);
        lat = 0;
        rready = 1'b1;
        while (!rvalid && lat < 100) begin @(negedge clk); lat++; end
        if (lat >= 100) timeout("r");
        data = rdata; resp = rresp; last = rlast; id = rid;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic write_single(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                input logic [63:0] data, input logic [7:0] strb,
                                input logic [1:0] exp_resp);
        logic [3:0] b_id;
        logic [1:0] b_resp;
        int lat;
        aw_send(id, addr, 8'd0, 3'd3, 2'd1);
        w_send(data, strb, 1'b1);
        b_recv(b_id, b_resp, lat);
        check({tag, "_bresp"}, 64'(b_resp), 64'(exp_resp));
        check({tag, "_bid"}, 64'(b_id), 64'(id));
    endtask

    task automatic read_check(input string tag, input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [1:0] burst,
                              input logic [63:0] exp [8], input logic [1:0] exp_resp,
                              input bit chk_lat);
        logic [63:0] d;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  r_id;
        int          lat;
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(exp[i]);
        ar_send(id, addr, len, 3'd3, burst);
        for (int i = 0; i <= int'(len); i++) begin
            r_recv(d, resp, last, r_id, lat);
            check($sformatf("%s_data%0d", tag, i), d, exp_q.pop_front());
            check($sformatf("%s_resp%0d", tag, i), 64'(resp), 64'(exp_resp));
            check($sformatf("%s_last%0d", tag, i), 64'(last), 64'(i == int'(len)));
            if (i == 0) check($sformatf("%s_rid", tag), 64'(r_id), 64'(id));
            if (chk_lat && i == 0) check($sformatf("%s_rlat", tag), 64'(lat), 64'd5);
        end
    endtask

    initial begin
        logic [3:0]  b_id, r_id;
        logic [1:0]  b_resp, resp;
        logic [63:0] d;
        logic        last;
        int          lat;

        reset_i = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Clock/reset block.
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_bid", 64'(bid), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        check("idle_awready", 64'(awready), 64'd1);
        check("idle_arready", 64'(arready), 64'd1);

        // INCR write len 3 with write latency measurement.
        aw_send(4'd5, 32'h100, 8'd3, 3'd3, 2'd1);
        w_send(64'h11, 8'hFF, 1'b0);
        w_send(64'h22, 8'hFF, 1'b0);
        w_send(64'h33, 8'hFF, 1'b0);
        w_send(64'h44, 8'hFF, 1'b1);
        b_recv(b_id, b_resp, lat);
        check("incr_w_bresp", 64'(b_resp), 64'd0);
        check("incr_w_bid", 64'(b_id), 64'd5);
        check("incr_w_blat", 64'(lat), 64'd2);

        read_check("incr_r", 4'd9, 32'h100, 8'd3, 2'd1,
                   '{64'h11, 64'h22, 64'h33, 64'h44, 64'h0, 64'h0, 64'h0, 64'h0}, 2'd0, 1'b1);
        read_check("wrap_r", 4'd1, 32'h118, 8'd3, 2'd2,
                   '{64'h44, 64'h11, 64'h22, 64'h33, 64'h0, 64'h0, 64'h0, 64'h0}, 2'd0, 1'b0);

        // Byte strobes.
        write_single("strb_a", 4'd2, 32'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd0);
        write_single("strb_b", 4'd2, 32'h200, 64'h0000_0000_1234_5678, 8'h0F, 2'd0);
        read_check("strb_r", 4'd3, 32'h200, 8'd0, 2'd1,
                   '{64'hFFFF_FFFF_1234_5678, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
                   2'd0, 1'b0);

        // Out-of-range write is dropped (word 0 is where a truncated index would land).
        write_single("w0", 4'd1, 32'h0, 64'hAAAA_5555_0000_1234, 8'hFF, 2'd0);
        write_single("oor_w", 4'd4, 32'h2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'd2);
        read_check("oor_keep", 4'd5, 32'h0, 8'd0, 2'd1,
                   '{64'hAAAA_5555_0000_1234, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
                   2'd0, 1'b0);
        read_check("oor_r", 4'd6, 32'h2000, 8'd0, 2'd1,
                   '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 2'd2, 1'b0);

        // FIXED burst keeps hitting one word; burst type 3 is an error.
        aw_send(4'd7, 32'h1C0, 8'd1, 3'd3, 2'd0);
        w_send(64'h77, 8'hFF, 1'b0);
        w_send(64'h88, 8'hFF, 1'b1);
        b_recv(b_id, b_resp, lat);
        check("fixed_w_bresp", 64'(b_resp), 64'd0);
        read_check("fixed_r", 4'd8, 32'h1C0, 8'd1, 2'd0,
                   '{64'h88, 64'h88, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 2'd0, 1'b0);
        read_check("burst3_r", 4'd2, 32'h100, 8'd0, 2'd3,
                   '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 2'd2, 1'b0);

        // Stall the last beat of an INCR read for three cycles.
        ar_send(4'd2, 32'h100, 8'd3, 3'd3, 2'd1);
        r_recv(d, resp, last, r_id, lat);
        check("stall_d0", d, 64'h11);
        r_recv(d, resp, last, r_id, lat);
        check("stall_d1", d, 64'h22);
        r_recv(d, resp, last, r_id, lat);
        check("stall_d2", d, 64'h33);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_valid%0d", c), 64'(rvalid), 64'd1);
            check($sformatf("stall_data%0d", c), rdata, 64'h44);
            check($sformatf("stall_last%0d", c), 64'(rlast), 64'd1);
            @(negedge clk);
        end
        r_recv(d, resp, last, r_id, lat);
        check("stall_d3", d, 64'h44);
        check("stall_l3", 64'(last), 64'd1);

        // wlast on the wrong beat.
        aw_send(4'd6, 32'h300, 8'd3, 3'd3, 2'd1);
        w_send(64'h1, 8'hFF, 1'b0);
        w_send(64'h2, 8'hFF, 1'b1);
        w_send(64'h3, 8'hFF, 1'b0);
        w_send(64'h4, 8'hFF, 1'b1);
        b_recv(b_id, b_resp, lat);
        check("wlast_bresp", 64'(b_resp), 64'd2);
        check("wlast_bid", 64'(b_id), 64'd6);

        // Reset during beat 2 of a len-7 read.
        ar_send(4'd7, 32'h100, 8'd7, 3'd3, 2'd1);
        r_recv(d, resp, last, r_id, lat);
        check("rst_mid_d0", d, 64'h11);
        r_recv(d, resp, last, r_id, lat);
        check("rst_mid_d1", d, 64'h22);
        check("rst_mid_v2", 64'(rvalid), 64'd1);
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_mid_rvalid", 64'(rvalid), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_mid_arready", 64'(arready), 64'd1);
        check("rst_mid_rvalid2", 64'(rvalid), 64'd0);

        aw_send(4'd3, 32'h180, 8'd1, 3'd3, 2'd1);
        w_send(64'h55, 8'hFF, 1'b0);
        w_send(64'h66, 8'hFF, 1'b1);
        b_recv(b_id, b_resp, lat);
        check("post_w_bresp", 64'(b_resp), 64'd0);
        check("post_w_bid", 64'(b_id), 64'd3);
        read_check("post_r", 4'd4, 32'h180, 8'd1, 2'd1,
                   '{64'h55, 64'h66, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0}, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
